// File: rtl/walk_pkg.sv
// Shared types and helpers for the multi-crossing pedestrian walk request bank.
package walk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } grant_state_t;

    // Index width for a channel number; a single channel still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int age_sat(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/walk_request_bank_rr_pick.sv
// Round-robin finder: first set bit of req at or after ptr, wrapping past the top channel.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int j;

    // Scan from the farthest offset down so the nearest hit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/walk_request_bank.sv
// Captures button edges on N crossings, ages pending requests, and offers them
// one at a time to the light controller with urgent-first round-robin arbitration.
module walk_request_bank
    import walk_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int AGE_W      = 8,
    parameter  int URGENT_AGE = 60,
    localparam int PW         = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [N_CH-1:0] WR_Sync,
    input  logic [N_CH-1:0] WR_Clr,
    input  logic            Tick,
    output logic [N_CH-1:0] WR,
    output logic [N_CH-1:0] WR_Urgent,
    output logic            Grant_Valid,
    output logic [PW-1:0]   Grant_Ch,
    output logic            Grant_Urgent,
    input  logic            Grant_Ack
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(age_sat(AGE_W));
    localparam logic [AGE_W-1:0] URG_TH  = AGE_W'(URGENT_AGE);
    localparam logic [PW-1:0]    LAST_CH = PW'(N_CH - 1);

    grant_state_t    state_q;
    logic [PW-1:0]   ptr_q;
    logic [N_CH-1:0] hist_q;
    logic [AGE_W-1:0] age_q [N_CH];
    logic [AGE_W-1:0] age_d [N_CH];

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] ack_vec;
    logic [N_CH-1:0] kill;
    logic [N_CH-1:0] wr_d;
    logic [N_CH-1:0] urg_d;
    logic [N_CH-1:0] elig_pend;
    logic [N_CH-1:0] elig_urg;
    logic            offer_clr;
    logic            offer_ack;
    logic            urg_found;
    logic            pend_found;
    logic [PW-1:0]   urg_idx;
    logic [PW-1:0]   pend_idx;

    assign rise      = WR_Sync & ~hist_q;
    assign offer_clr = (state_q == OFFER) && WR_Clr[Grant_Ch];
    assign offer_ack = (state_q == OFFER) && Grant_Ack && !offer_clr;

    // A channel being cleared this cycle is not a candidate for the next offer.
    assign elig_pend = WR & ~WR_Clr;
    assign elig_urg  = WR_Urgent & ~WR_Clr;

    rr_pick #(.N(N_CH), .PW(PW)) u_pick_urg (
        .req   (elig_urg),
        .ptr   (ptr_q),
        .found (urg_found),
        .idx   (urg_idx)
    );

    rr_pick #(.N(N_CH), .PW(PW)) u_pick_pend (
        .req   (elig_pend),
        .ptr   (ptr_q),
        .found (pend_found),
        .idx   (pend_idx)
    );

    // Clear beats a new edge; an ack only drops the old request, so a
    // coincident edge re-arms the channel with a fresh age.
    always_comb begin
        ack_vec = '0;
        kill    = '0;
        wr_d    = '0;
        urg_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            ack_vec[i] = offer_ack && (Grant_Ch == PW'(i));
            kill[i]    = WR_Clr[i] || ack_vec[i];
            wr_d[i]    = !WR_Clr[i] && ((WR[i] && !ack_vec[i]) || rise[i]);
            urg_d[i]   = WR[i] && !kill[i] && (age_q[i] >= URG_TH);
            if (kill[i] || !WR[i]) begin
                age_d[i] = '0;
            end else if (Tick && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            hist_q    <= '0;
            WR        <= '0;
            WR_Urgent <= '0;
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            hist_q    <= WR_Sync;
            WR        <= wr_d;
            WR_Urgent <= urg_d;
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // A withdrawn offer leaves the pointer alone; only a real ack advances fairness.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            Grant_Valid  <= 1'b0;
            Grant_Ch     <= '0;
            Grant_Urgent <= 1'b0;
            ptr_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (urg_found) begin
                        state_q      <= OFFER;
                        Grant_Valid  <= 1'b1;
                        Grant_Ch     <= urg_idx;
                        Grant_Urgent <= 1'b1;
                    end else if (pend_found) begin
                        state_q      <= OFFER;
                        Grant_Valid  <= 1'b1;
                        Grant_Ch     <= pend_idx;
                        Grant_Urgent <= 1'b0;
                    end
                end
                OFFER: begin
                    if (offer_clr) begin
                        state_q     <= IDLE;
                        Grant_Valid <= 1'b0;
                    end else if (offer_ack) begin
                        state_q     <= IDLE;
                        Grant_Valid <= 1'b0;
                        ptr_q       <= (Grant_Ch == LAST_CH) ? '0 : Grant_Ch + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_walk_request_bank.sv
// Directed bench for walk_request_bank with a per-cycle request/grant model.
module tb_walk_request_bank;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int UA = 3;
    localparam int PW = 2;
    localparam int AGE_TOP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          Reset;
    logic [N-1:0]  btn;
    logic [N-1:0]  clr;
    logic          tick;
    logic          ack;
    logic [N-1:0]  wr;
    logic [N-1:0]  wr_urg;
    logic          gv;
    logic [PW-1:0] gch;
    logic          gurg;

    int checks = 0;
    int errors = 0;

    bit m_pend [N];
    int m_age  [N];
    bit m_urg  [N];
    bit m_prev [N];
    bit m_valid;
    int m_gch;
    bit m_gurg;
    int m_ptr;

    int  grants;
    bit  prev_gv;
    bit  t2_acked;
    logic a_now;

    always #5 clk = ~clk;

    walk_request_bank #(.N_CH(N), .AGE_W(AW), .URGENT_AGE(UA)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .WR_Sync      (btn),
        .WR_Clr       (clr),
        .Tick         (tick),
        .WR           (wr),
        .WR_Urgent    (wr_urg),
        .Grant_Valid  (gv),
        .Grant_Ch     (gch),
        .Grant_Urgent (gurg),
        .Grant_Ack    (ack)
    );

    function automatic void chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_age[i]  = 0;
            m_urg[i]  = 0;
            m_prev[i] = 0;
        end
        m_valid = 0;
        m_gch   = 0;
        m_gurg  = 0;
        m_ptr   = 0;
    endfunction

    // One clock of the request bank, computed from the pre-edge state and inputs.
    function automatic void model_clock();
        bit n_pend [N];
        int n_age  [N];
        bit n_urg  [N];
        bit clr_hit, ack_ok, acked, rse, found_u, found_p;
        int cand, pick_u, pick_p;
        clr_hit = m_valid && clr[m_gch];
        ack_ok  = m_valid && ack && !clr_hit;
        for (int i = 0; i < N; i++) begin
            rse   = btn[i] && !m_prev[i];
            acked = ack_ok && (m_gch == i);
            if (clr[i])     n_pend[i] = 0;
            else if (acked) n_pend[i] = rse;
            else            n_pend[i] = m_pend[i] || rse;
            if (clr[i] || acked || !m_pend[i]) n_age[i] = 0;
            else if (tick) n_age[i] = (m_age[i] < AGE_TOP) ? m_age[i] + 1 : AGE_TOP;
            else           n_age[i] = m_age[i];
            n_urg[i] = m_pend[i] && !clr[i] && !acked && (m_age[i] >= UA);
        end
        if (m_valid) begin
            if (clr_hit) begin
                m_valid = 0;
            end else if (ack_ok) begin
                m_valid = 0;
                m_ptr   = (m_gch + 1) % N;
            end
        end else begin
            found_u = 0; found_p = 0; pick_u = 0; pick_p = 0;
            for (int k = 0; k < N; k++) begin
                cand = (m_ptr + k) % N;
                if (!found_u && m_urg[cand] && !clr[cand])  begin found_u = 1; pick_u = cand; end
                if (!found_p && m_pend[cand] && !clr[cand]) begin found_p = 1; pick_p = cand; end
            end
            if (found_u) begin
                m_valid = 1; m_gch = pick_u; m_gurg = 1;
            end else if (found_p) begin
                m_valid = 1; m_gch = pick_p; m_gurg = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = n_pend[i];
            m_age[i]  = n_age[i];
            m_urg[i]  = n_urg[i];
            m_prev[i] = btn[i];
        end
    endfunction

    function automatic void check_output();
        int e_wr, e_urg;
        e_wr = 0; e_urg = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) e_wr  |= (1 << i);
            if (m_urg[i])  e_urg |= (1 << i);
        end
        chk("model_wr", int'(wr), e_wr);
        chk("model_urgent", int'(wr_urg), e_urg);
        chk("model_valid", int'(gv), int'(m_valid));
        if (m_valid) begin
            chk("model_ch", int'(gch), m_gch);
            chk("model_gurg", int'(gurg), int'(m_gurg));
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (Reset) model_reset();
        else       model_clock();
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(input logic [N-1:0] b, input logic [N-1:0] c,
                                  input logic t, input logic a);
        btn  = b;
        clr  = c;
        tick = t;
        ack  = a;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_grant(input int exp_ch, input string tag);
        int n = 0;
        while (!gv && n < 6) begin
            apply_stimulus('0, '0, 1'b0, 1'b0);
            n++;
        end
        chk({tag, "_valid"}, int'(gv), 1);
        chk({tag, "_ch"}, int'(gch), exp_ch);
        apply_stimulus('0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b1; btn = '0; clr = '0; tick = 1'b0; ack = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_wr", int'(wr), 0);
        chk("rst_urgent", int'(wr_urg), 0);
        chk("rst_valid", int'(gv), 0);
        chk("rst_ch", int'(gch), 0);
        chk("rst_gurg", int'(gurg), 0);
        Reset = 1'b0;

        // Single press on ch2; stray acks while nothing is offered are ignored.
        apply_stimulus(4'b0100, '0, 1'b0, 1'b1);
        chk("t1_wr", int'(wr), 4);
        chk("t1_idle", int'(gv), 0);
        apply_stimulus('0, '0, 1'b0, 1'b1);
        chk("t1_valid", int'(gv), 1);
        chk("t1_ch", int'(gch), 2);
        apply_stimulus('0, '0, 1'b0, 1'b1);
        chk("t1_wr_after_ack", int'(wr), 0);
        chk("t1_valid_after_ack", int'(gv), 0);
        apply_stimulus('0, '0, 1'b0, 1'b0);

        // Held button gives exactly one grant.
        grants = 0; prev_gv = 0; t2_acked = 0;
        for (int c = 0; c < 50; c++) begin
            a_now = gv && !t2_acked;
            if (a_now) t2_acked = 1;
            apply_stimulus(4'b0010, '0, 1'b0, a_now);
            if (gv && !prev_gv) grants++;
            prev_gv = gv;
        end
        chk("t2_grants", grants, 1);
        chk("t2_wr", int'(wr), 0);
        apply_stimulus('0, '0, 1'b0, 1'b0);

        // Round-robin order from a fresh pointer, then again after the wrap.
        do_reset();
        apply_stimulus(4'b1111, '0, 1'b0, 1'b0);
        chk("t3_wr", int'(wr), 15);
        for (int k = 0; k < N; k++) wait_grant(k, "t3_first");
        apply_stimulus(4'b1111, '0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) wait_grant(k, "t3_second");

        // Ch1 held on offer while ch3 ages to urgent; withdrawing ch1 lets urgent ch3 jump ch0.
        apply_stimulus(4'b0010, '0, 1'b0, 1'b0);
        apply_stimulus(4'b1000, '0, 1'b0, 1'b0);
        chk("t4_offer_ch", int'(gch), 1);
        for (int k = 0; k < 4; k++) apply_stimulus('0, '0, 1'b1, 1'b0);
        chk("t4_urgent3", int'(wr_urg[3]), 1);
        apply_stimulus(4'b0001, '0, 1'b0, 1'b0);
        chk("t4_wr", int'(wr), 11);
        apply_stimulus('0, 4'b0010, 1'b0, 1'b0);
        chk("t4_withdrawn", int'(gv), 0);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t4_urgent_ch", int'(gch), 3);
        chk("t4_urgent_flag", int'(gurg), 1);
        apply_stimulus('0, '0, 1'b0, 1'b1);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t4_next_ch", int'(gch), 0);
        chk("t4_next_flag", int'(gurg), 0);
        apply_stimulus('0, '0, 1'b0, 1'b1);

        // Clear beats ack: pointer stays on ch1.
        apply_stimulus(4'b0010, '0, 1'b0, 1'b0);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t5_offer_ch", int'(gch), 1);
        apply_stimulus('0, 4'b0010, 1'b0, 1'b1);
        chk("t5_wr", int'(wr), 0);
        chk("t5_valid", int'(gv), 0);
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t5_ptr_kept", int'(gch), 1);
        apply_stimulus('0, '0, 1'b0, 1'b1);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t5_then_ch2", int'(gch), 2);
        apply_stimulus(4'b0100, '0, 1'b0, 1'b1);
        chk("t5_edge_on_ack", int'(wr), 4);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t5_reoffer", int'(gch), 2);
        apply_stimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
        chk("t5_clear_wins", int'(wr), 0);
        apply_stimulus('0, '0, 1'b0, 1'b0);

        // Saturating ages keep urgency, then async reset mid-offer wipes everything.
        apply_stimulus(4'b1010, '0, 1'b0, 1'b0);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t6_offer_ch", int'(gch), 3);
        for (int k = 0; k < 10; k++) apply_stimulus('0, '0, 1'b1, 1'b0);
        chk("t6_sat_urgent", int'(wr_urg), 10);
        #3 Reset = 1'b1;
        #1;
        chk("t6_async_valid", int'(gv), 0);
        chk("t6_async_wr", int'(wr), 0);
        chk("t6_async_urgent", int'(wr_urg), 0);
        model_reset();
        tick = 1'b0;
        step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) apply_stimulus('0, '0, 1'b0, 1'b0);
        chk("t6_no_grant", int'(gv), 0);

        // Button high across reset release counts as one press.
        btn = 4'b0001;
        do_reset();
        apply_stimulus(4'b0001, '0, 1'b0, 1'b0);
        chk("t7_wr", int'(wr), 1);
        apply_stimulus(4'b0001, '0, 1'b0, 1'b0);
        apply_stimulus(4'b0001, '0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) apply_stimulus(4'b0001, '0, 1'b0, 1'b0);
        chk("t7_wr_after", int'(wr), 0);
        chk("t7_valid_after", int'(gv), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
